rr_arbiter8: RTL and testbench

Eight-requester round-robin arbiter with grant lock and bounded hold time. It shares one downstream resource among eight requesters. It emits a one-hot grant plus the binary-encoded index of the winner, so downstream logic consumes the index directly instead of re-encoding the one-hot vector. Fairness comes from a rotating priority pointer. Starvation is bounded by a hold counter that forces rotation when other requesters wait.

---
 rtl/arb_pkg.sv | 17 +
 rtl/rr_pick.sv | 29 ++
 rtl/rr_arbiter8.sv | 100 ++++++++++
 tb/tb_rr_arbiter8.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the eight-way round-robin arbiter.
package arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Turn a requester index into its one-hot grant bit.
    function automatic logic [N_REQ-1:0] onehot8(input logic [IDX_W-1:0] idx);
        onehot8 = {{(N_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority search: first set bit of cand at or after start, wrapping 7 to 0.
module rr_pick
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] cand,
    input  logic [IDX_W-1:0] start,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    logic [2*N_REQ-1:0] doubled;
    logic [N_REQ-1:0]   rotated;
    logic [IDX_W-1:0]   offset;

    // Rotate so start sits at bit 0, priority-encode the lowest set bit, then add start back.
    always_comb begin
        doubled = {cand, cand} >> start;
        rotated = doubled[N_REQ-1:0];
        offset  = '0;
        found   = |rotated;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = IDX_W'(i);
            end
        end
        idx = offset + start;
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter with grant lock and bounded hold time.
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    localparam int HC_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [HC_W-1:0] HOLD_LAST = (HOLD_MAX > 0) ? HC_W'(HOLD_MAX - 1) : '0;

    arb_state_t       state;
    arb_state_t       state_next;
    logic [IDX_W-1:0] last_idx;
    logic [HC_W-1:0]  hold_cnt;
    logic             owner_req;
    logic             preempt_sel;
    logic [N_REQ-1:0] cand;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;
    logic             new_grant;

    assign owner_req = req[gnt_idx];
    assign gnt_valid = (state == GRANT);

    // Preemption restricts the search to waiters other than the current owner.
    always_comb begin
        preempt_sel = (HOLD_MAX != 0) && (state == GRANT) && owner_req &&
                      (hold_cnt == HOLD_LAST) && (|(req & ~gnt));
        cand        = preempt_sel ? (req & ~gnt) : req;
    end

    rr_pick u_pick (
        .cand  (cand),
        .start (last_idx + 3'd1),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Next-state logic: decide whether this edge hands out a new grant or drops to idle.
    always_comb begin
        state_next = state;
        new_grant  = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_next = GRANT;
                    new_grant  = 1'b1;
                end
            end
            GRANT: begin
                if (!owner_req) begin
                    if (pick_found) begin
                        new_grant = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (preempt_sel) begin
                    new_grant = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grant outputs, rotation pointer and hold counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt      <= '0;
            gnt_idx  <= '0;
            last_idx <= 3'd7;
            hold_cnt <= '0;
        end else if (new_grant) begin
            gnt      <= onehot8(pick_idx);
            gnt_idx  <= pick_idx;
            last_idx <= pick_idx;
            hold_cnt <= '0;
        end else if (state_next == IDLE) begin
            gnt <= '0;
        end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench: two arbiters (hold limits 4 and 1) against a cycle-level reference model.
module tb_rr_arbiter8;
    import arb_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt_a, gnt_b;
    logic [2:0] idx_a, idx_b;
    logic       valid_a, valid_b;

    int checks = 0;
    int errors = 0;

    int hold_of [2] = '{4, 1};
    int m_owner [2];
    int m_last  [2];
    int m_age   [2];

    rr_arbiter8 #(.HOLD_MAX(4)) dut_a (
        .clk(clk), .rst(rst), .req(req),
        .gnt(gnt_a), .gnt_idx(idx_a), .gnt_valid(valid_a)
    );

    rr_arbiter8 #(.HOLD_MAX(1)) dut_b (
        .clk(clk), .rst(rst), .req(req),
        .gnt(gnt_b), .gnt_idx(idx_b), .gnt_valid(valid_b)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Count one comparison and report it if it does not match.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // First set bit of cand found by scanning upward from start with wrap; -1 if none.
    function automatic int scanFrom(input logic [7:0] cand, input int start);
        for (int k = 0; k < 8; k++) begin
            int i;
            i = (start + k) % 8;
            if (cand[i]) return i;
        end
        return -1;
    endfunction

    // Advance the reference model for arbiter u by one clock edge.
    task automatic modelStep(input int u);
        int          w;
        logic [7:0]  others;
        if (rst) begin
            m_owner[u] = -1;
            m_last[u]  = 7;
            m_age[u]   = 0;
        end else if (m_owner[u] < 0) begin
            w = scanFrom(req, m_last[u] + 1);
            if (w >= 0) begin
                m_owner[u] = w; m_last[u] = w; m_age[u] = 1;
            end
        end else if (!req[m_owner[u]]) begin
            w = scanFrom(req, m_last[u] + 1);
            if (w >= 0) begin
                m_owner[u] = w; m_last[u] = w; m_age[u] = 1;
            end else begin
                m_owner[u] = -1;
            end
        end else begin
            others = req & ~(8'd1 << m_owner[u]);
            if (hold_of[u] > 0 && m_age[u] >= hold_of[u] && others != 8'd0) begin
                w = scanFrom(others, m_last[u] + 1);
                m_owner[u] = w; m_last[u] = w; m_age[u] = 1;
            end else begin
                m_age[u]++;
            end
        end
    endtask

    // Compare both arbiters against the model.
    task automatic compareModel();
        logic [7:0] eg;
        eg = (m_owner[0] < 0) ? 8'd0 : (8'd1 << m_owner[0]);
        checkOutput("gnt_a", {24'd0, gnt_a}, {24'd0, eg});
        checkOutput("valid_a", {31'd0, valid_a}, {31'd0, (m_owner[0] >= 0)});
        if (m_owner[0] >= 0) checkOutput("idx_a", {29'd0, idx_a}, m_owner[0]);
        eg = (m_owner[1] < 0) ? 8'd0 : (8'd1 << m_owner[1]);
        checkOutput("gnt_b", {24'd0, gnt_b}, {24'd0, eg});
        checkOutput("valid_b", {31'd0, valid_b}, {31'd0, (m_owner[1] >= 0)});
        if (m_owner[1] >= 0) checkOutput("idx_b", {29'd0, idx_b}, m_owner[1]);
    endtask

    // Drive one cycle of inputs, step the model on the edge, then check shortly after.
    task automatic applyStimulus(input logic [7:0] r, input logic rs);
        req = r;
        rst = rs;
        @(posedge clk);
        modelStep(0);
        modelStep(1);
        #2;
        compareModel();
    endtask

    initial begin
        logic [7:0] r;
        logic       rs;
        req = 8'h00;
        rst = 1'b1;

        // Reset with requests already pending: outputs stay zero.
        applyStimulus(8'h05, 1'b1);
        applyStimulus(8'h05, 1'b1);
        checkOutput("reset_gnt", {24'd0, gnt_a}, 32'h0);
        checkOutput("reset_idx", {29'd0, idx_a}, 32'h0);
        checkOutput("reset_valid", {31'd0, valid_a}, 32'h0);
        applyStimulus(8'h05, 1'b0);
        checkOutput("first_gnt", {24'd0, gnt_a}, 32'h01);
        checkOutput("first_idx", {29'd0, idx_a}, 32'h0);

        // Release hands off without a bubble, then everyone leaves.
        applyStimulus(8'h04, 1'b0);
        checkOutput("handoff_gnt", {24'd0, gnt_a}, 32'h04);
        checkOutput("handoff_idx", {29'd0, idx_a}, 32'h2);
        applyStimulus(8'h00, 1'b0);
        checkOutput("idle_valid", {31'd0, valid_a}, 32'h0);

        // Wrap-around: last winner 6, search passes 7 and lands on 0.
        applyStimulus(8'h40, 1'b0);
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h41, 1'b0);
        checkOutput("wrap_idx", {29'd0, idx_a}, 32'h0);
        applyStimulus(8'h40, 1'b0);
        checkOutput("wrap_next_idx", {29'd0, idx_a}, 32'h6);

        // Preemption with hold limit 4: 0 x4, 1 x4, 0 x4.
        applyStimulus(8'h00, 1'b0);
        for (int k = 0; k < 12; k++) begin
            applyStimulus(8'h03, 1'b0);
            checkOutput("preempt_idx", {29'd0, idx_a}, ((k / 4) % 2 == 0) ? 32'h0 : 32'h1);
        end
        for (int k = 0; k < 10; k++) begin
            applyStimulus(8'h01, 1'b0);
            checkOutput("lone_owner_idx", {29'd0, idx_a}, 32'h0);
        end

        // Reset in the middle of a grant to requester 5.
        applyStimulus(8'h00, 1'b0);
        for (int k = 0; k < 3; k++) applyStimulus(8'h20, 1'b0);
        applyStimulus(8'h20, 1'b1);
        checkOutput("midreset_gnt", {24'd0, gnt_a}, 32'h0);
        applyStimulus(8'hA0, 1'b0);
        checkOutput("after_reset_idx", {29'd0, idx_a}, 32'h5);

        // Fairness soak with everyone requesting.
        applyStimulus(8'h00, 1'b1);
        for (int k = 0; k < 17; k++) begin
            applyStimulus(8'hFF, 1'b0);
            checkOutput("soak_idx_b", {29'd0, idx_b}, k % 8);
            checkOutput("soak_onehot_b", $countones(gnt_b), 32'd1);
            checkOutput("soak_idx_a", {29'd0, idx_a}, (k / 4) % 8);
        end

        // Randomized traffic with sparse toggles and occasional resets.
        r = 8'h00;
        for (int k = 0; k < 3000; k++) begin
            r  = r ^ 8'($urandom_range(0, 255) & $urandom_range(0, 255) & $urandom_range(0, 255));
            rs = ($urandom_range(0, 199) == 0);
            applyStimulus(r, rs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
